// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: 6-digit hex/signed-decimal display sequencer with double-dabble conversion.
// Optional blink gating is enabled by defining HEX_BLINK_EN.
module hex_display_ctrl #(
   parameter int SIGN_LEFT = 0
`ifdef HEX_BLINK_EN
   , parameter int BLINK_DIV = 25_000_000
`endif
) (
   input  logic        CLK,
   input  logic        RST,
`ifdef HEX_BLINK_EN
   input  logic        BLINK,
`endif
   input  logic [15:0] VALUE,
   input  logic        MODE,
   input  logic [2:0]  DP_POS,
   input  logic        LOAD,
   output logic        READY,
   output logic [23:0] NUM_BUS,
   output logic [5:0]  DEC_BUS,
   output logic [5:0]  SIGN_BUS,
   output logic [5:0]  OFF_BUS
);
   typedef enum logic [1:0] {IDLE, CAPT, CONV, PLACE} state_t;
   state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] val_q, val_d, bin_q, bin_d;
   logic        mode_q, mode_d, neg_q, neg_d;
   logic [2:0]  dp_q, dp_d;
   logic [19:0] bcd_q, bcd_d, adj;
   logic [23:0] num_q, num_d, digs;
   logic [5:0]  dec_q, dec_d, sign_q, sign_d, off_q, off_d;
   logic [2:0]  msd, top, sp;
   logic        dp_ok, sv, show, is_sign;
   assign READY = state_q == IDLE;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      mode_d  = mode_q;
      dp_d    = dp_q;
      neg_d   = neg_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      num_d   = num_q;
      dec_d   = dec_q;
      sign_d  = sign_q;
      off_d   = off_q;
      show    = 1'b0;
      is_sign = 1'b0;
      for (int i = 0; i < 5; i++)
         adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
      digs = {4'h0, bcd_q};
      msd  = 3'd0;
      for (int i = 0; i < 5; i++)
         if (bcd_q[4*i+:4] != 4'h0) msd = 3'(i);
      dp_ok = dp_q <= 3'd5;
      top   = (dp_ok && dp_q > msd) ? dp_q : msd;
      sp    = SIGN_LEFT != 0 ? 3'd5 : 3'(top + 3'd1);
      // a top of 5 leaves no room on the left, so the sign is suppressed there
      sv    = neg_q && (SIGN_LEFT != 0 || top < 3'd5);
      case (state_q)
         IDLE: if (LOAD) begin
            val_d   = VALUE;
            mode_d  = MODE;
            dp_d    = DP_POS;
            state_d = CAPT;
         end
         CAPT: begin
            neg_d   = !mode_q && val_q[15];
            bin_d   = (!mode_q && val_q[15]) ? 16'(16'd0 - val_q) : val_q;
            bcd_d   = mode_q ? {4'h0, val_q} : 20'h0;
            cnt_d   = 4'd0;
            state_d = mode_q ? PLACE : CONV;
         end
         CONV: begin
            {bcd_d, bin_d} = {adj[18:0], bin_q, 1'b0};
            cnt_d   = cnt_q + 4'd1;
            state_d = cnt_q == 4'd15 ? PLACE : CONV;
         end
         PLACE: begin
            for (int d = 0; d < 6; d++) begin
               show            = 3'(d) <= top;
               is_sign         = sv && 3'(d) == sp;
               off_d[d]        = !(show || is_sign);
               sign_d[d]       = is_sign;
               dec_d[d]        = dp_ok && 3'(d) == dp_q;
               num_d[4*d+:4]   = (show && !is_sign) ? digs[4*d+:4] : 4'h0;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         val_q   <= '0;
         mode_q  <= 1'b0;
         dp_q    <= '0;
         neg_q   <= 1'b0;
         bin_q   <= '0;
         bcd_q   <= '0;
         num_q   <= '0;
         dec_q   <= '0;
         sign_q  <= '0;
         off_q   <= 6'b111111;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         mode_q  <= mode_d;
         dp_q    <= dp_d;
         neg_q   <= neg_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         num_q   <= num_d;
         dec_q   <= dec_d;
         sign_q  <= sign_d;
         off_q   <= off_d;
      end
   end
   assign NUM_BUS  = num_q;
   assign SIGN_BUS = sign_q;
`ifdef HEX_BLINK_EN
   logic [24:0] div_q, div_d;
   logic        phase_q, phase_d, wrap;
   always_comb begin
      wrap    = div_q == 25'(BLINK_DIV - 1);
      div_d   = BLINK ? (wrap ? 25'd0 : div_q + 25'd1) : 25'd0;
      phase_d = BLINK ? phase_q ^ wrap : 1'b0;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         div_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         phase_q <= phase_d;
      end
   end
   assign OFF_BUS = off_q | {6{phase_q}};
   assign DEC_BUS = dec_q & ~{6{phase_q}};
`else
   assign OFF_BUS = off_q;
   assign DEC_BUS = dec_q;
`endif
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: directed vector table plus handshake, drop and reset sequences.
module tb_hex_display_ctrl;
   logic        clk = 1'b0, rst = 1'b1, load = 1'b0, mode = 1'b0;
   logic [15:0] value = '0;
   logic [2:0]  dp_pos = 3'd7;
   logic        ready;
   logic [23:0] num_bus;
   logic [5:0]  dec_bus, sign_bus, off_bus;
   int checks = 0, errors = 0;

   hex_display_ctrl dut (
      .CLK(clk), .RST(rst), .VALUE(value), .MODE(mode), .DP_POS(dp_pos), .LOAD(load),
      .READY(ready), .NUM_BUS(num_bus), .DEC_BUS(dec_bus), .SIGN_BUS(sign_bus), .OFF_BUS(off_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] val;
      logic        md;
      logic [2:0]  dp;
      logic [23:0] num;
      logic [5:0]  dec, sign, off;
      int          lat;
   } vec_t;
   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [23:0] n, input logic [5:0] d, input logic [5:0] s, input logic [5:0] o);
      check({tag, " num"}, 32'(num_bus), 32'(n));
      check({tag, " dec"}, 32'(dec_bus), 32'(d));
      check({tag, " sign"}, 32'(sign_bus), 32'(s));
      check({tag, " off"}, 32'(off_bus), 32'(o));
   endtask

   task automatic run_vec(input int idx, input vec_t v, input logic [23:0] pn, input logic [5:0] pd, input logic [5:0] ps, input logic [5:0] po);
      int n;
      bit held;
      @(negedge clk);
      value = v.val; mode = v.md; dp_pos = v.dp; load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      check($sformatf("v%0d ready_low", idx), 32'(ready), 32'd0);
      n = 0;
      held = 1'b1;
      while (!ready && n < 40) begin
         if ({num_bus, dec_bus, sign_bus, off_bus} !== {pn, pd, ps, po}) held = 1'b0;
         @(posedge clk);
         #1 n++;
      end
      check($sformatf("v%0d latency", idx), 32'(n), 32'(v.lat));
      check($sformatf("v%0d held", idx), 32'(held), 32'd1);
      check_outs($sformatf("v%0d", idx), v.num, v.dec, v.sign, v.off);
   endtask

   initial begin
      logic [23:0] pn;
      logic [5:0]  pd, ps, po;
      int n;
      vecs[0]  = '{16'd1234,  1'b0, 3'd7, 24'h001234, 6'b000000, 6'b000000, 6'b110000, 18};
      vecs[1]  = '{16'hFFFB,  1'b0, 3'd7, 24'h000005, 6'b000000, 6'b000010, 6'b111100, 18};
      vecs[2]  = '{16'h8000,  1'b0, 3'd7, 24'h032768, 6'b000000, 6'b100000, 6'b000000, 18};
      vecs[3]  = '{16'd5,     1'b0, 3'd2, 24'h000005, 6'b000100, 6'b000000, 6'b111000, 18};
      vecs[4]  = '{16'h00AF,  1'b1, 3'd7, 24'h0000AF, 6'b000000, 6'b000000, 6'b111100, 2};
      vecs[5]  = '{16'd0,     1'b0, 3'd7, 24'h000000, 6'b000000, 6'b000000, 6'b111110, 18};
      vecs[6]  = '{16'hFFFF,  1'b1, 3'd5, 24'h00FFFF, 6'b100000, 6'b000000, 6'b000000, 2};
      vecs[7]  = '{16'd32767, 1'b0, 3'd0, 24'h032767, 6'b000001, 6'b000000, 6'b100000, 18};
      vecs[8]  = '{16'hFFFF,  1'b0, 3'd3, 24'h000001, 6'b001000, 6'b010000, 6'b100000, 18};
      vecs[9]  = '{16'h8000,  1'b1, 3'd6, 24'h008000, 6'b000000, 6'b000000, 6'b110000, 2};
      vecs[10] = '{16'd100,   1'b0, 3'd7, 24'h000100, 6'b000000, 6'b000000, 6'b111000, 18};

      repeat (3) @(posedge clk);
      #1 check("reset ready", 32'(ready), 32'd1);
      check_outs("reset", 24'h0, 6'b0, 6'b0, 6'b111111);
      @(negedge clk) rst = 1'b0;

      pn = 24'h0; pd = 6'b0; ps = 6'b0; po = 6'b111111;
      for (int i = 0; i < 11; i++) begin
         run_vec(i, vecs[i], pn, pd, ps, po);
         pn = vecs[i].num; pd = vecs[i].dec; ps = vecs[i].sign; po = vecs[i].off;
      end

      // LOAD during a conversion is dropped
      @(negedge clk);
      value = 16'd77; mode = 1'b0; dp_pos = 3'd7; load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      value = 16'd99; load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      check("drop ready_low", 32'(ready), 32'd0);
      n = 5;
      while (!ready && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      check("drop latency", 32'(n), 32'd18);
      check_outs("drop", 24'h000077, 6'b0, 6'b0, 6'b111100);

      // reset in the middle of a conversion
      @(negedge clk);
      value = 16'd1234; load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1 check("midrst ready", 32'(ready), 32'd1);
      check_outs("midrst", 24'h0, 6'b0, 6'b0, 6'b111111);
      @(negedge clk) rst = 1'b0;
      repeat (20) @(posedge clk);
      #1 check_outs("midrst idle", 24'h0, 6'b0, 6'b0, 6'b111111);

      // reset beats LOAD on the same edge
      @(negedge clk);
      rst = 1'b1; load = 1'b1; value = 16'd55;
      @(posedge clk);
      #1 rst = 1'b0; load = 1'b0;
      check("rstload ready", 32'(ready), 32'd1);
      repeat (20) @(posedge clk);
      #1 check_outs("rstload", 24'h0, 6'b0, 6'b0, 6'b111111);

      // LOAD held high re-accepts on the first idle edge
      @(negedge clk);
      value = 16'h00AF; mode = 1'b1; dp_pos = 3'd7; load = 1'b1;
      @(posedge clk);
      n = 0;
      #1;
      while (!ready && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      check("b2b first latency", 32'(n), 32'd2);
      check_outs("b2b first", 24'h0000AF, 6'b0, 6'b0, 6'b111100);
      @(posedge clk);
      #1 check("b2b reaccept", 32'(ready), 32'd0);
      load = 1'b0;
      n = 0;
      while (!ready && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      check("b2b second latency", 32'(n), 32'd2);
      check_outs("b2b second", 24'h0000AF, 6'b0, 6'b0, 6'b111100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
